// File: rtl/seq_bin2bcd_if.sv
// seq_bin2bcd_if: start/busy/done handshake and display word
// between the result path and the BCD converter.
interface seq_bin2bcd_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic             sign_i;
  logic [WIDTH-1:0] bin_i;
  logic             busy_o;
  logic             done_o;
  logic [15:0]      num_o;

  modport master (
    output start_i, sign_i, bin_i,
    input  busy_o, done_o, num_o
  );

  modport slave (
    input  start_i, sign_i, bin_i,
    output busy_o, done_o, num_o
  );
endinterface

// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd: iterative double-dabble producing the Seg7 word.
// Define SEQ_BIN2BCD_LZB_EN to blank leading zero digits.
module seq_bin2bcd #(
  parameter int         WIDTH      = 8,
  parameter logic [3:0] MINUS_CODE = 4'hA,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input logic          clk,
  input logic          rst,
  seq_bin2bcd_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_mag;
  logic [11:0]      r_bcd;
  logic             r_neg;
  logic [15:0]      r_num;

  logic             w_last;
  logic             w_accept;
  logic             w_neg;
  logic [WIDTH-1:0] w_mag;
  logic [11:0]      w_adj;
  logic [11:0]      w_bcd_nxt;
  logic [11:0]      w_digits;
  logic [3:0]       w_sign;
  logic             w_busy;
  logic             w_done;

  function automatic logic [3:0] add3(
    input logic [3:0] d
  );
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign w_last   = (r_cnt == 4'(WIDTH-1));
  assign w_accept = (r_state == S_IDLE)
                  & bus.start_i;
  assign w_neg    = bus.sign_i
                  & bus.bin_i[WIDTH-1];
  assign w_mag    = w_neg
                  ? (~bus.bin_i + WIDTH'(1))
                  : bus.bin_i;

  assign w_adj = {add3(r_bcd[11:8]),
                  add3(r_bcd[7:4]),
                  add3(r_bcd[3:0])};
  assign w_bcd_nxt = {w_adj[10:0],
                      r_mag[WIDTH-1]};

`ifdef SEQ_BIN2BCD_LZB_EN
  logic w_hun_blank;
  logic w_ten_blank;

  assign w_hun_blank = (w_bcd_nxt[11:8] == 4'd0);
  assign w_ten_blank = w_hun_blank
                     & (w_bcd_nxt[7:4] == 4'd0);
  assign w_digits = {
    w_hun_blank ? BLANK_CODE : w_bcd_nxt[11:8],
    w_ten_blank ? BLANK_CODE : w_bcd_nxt[7:4],
    w_bcd_nxt[3:0]
  };
`else
  assign w_digits = w_bcd_nxt;
`endif

  assign w_sign = r_neg ? MINUS_CODE : BLANK_CODE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start_i) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_SHIFT: w_busy = 1'b1;
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Final shift and display load share the last SHIFT edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_mag <= '0;
      r_bcd <= '0;
      r_neg <= 1'b0;
      r_num <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_mag <= w_mag;
      r_bcd <= '0;
      r_neg <= w_neg;
    end else if (r_state == S_SHIFT) begin
      r_cnt <= r_cnt + 4'd1;
      r_bcd <= w_bcd_nxt;
      r_mag <= {r_mag[WIDTH-2:0], 1'b0};
      if (w_last) r_num <= {w_sign, w_digits};
    end
  end

  assign bus.busy_o = w_busy;
  assign bus.done_o = w_done;
  assign bus.num_o  = r_num;
endmodule

// File: tb/tb_seq_bin2bcd.sv
// tb_seq_bin2bcd: directed vectors, handshake corners and a
// full back-to-back sweep against a decimal reference.
module tb_seq_bin2bcd;
`ifdef SEQ_BIN2BCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   n_exp_done = 0;

  always #5 clk = ~clk;

  seq_bin2bcd_if #(.WIDTH(8)) bus ();

  seq_bin2bcd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.done_o) n_done++;

  typedef struct {
    logic [7:0]  bin;
    logic        sign;
    logic [15:0] e_plain;
    logic [15:0] e_lzb;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [15:0] ref_num(
    input logic [7:0] b,
    input logic       s
  );
    int         v;
    logic       neg;
    logic [3:0] h, t, u;
    neg = s & b[7];
    v = neg ? 256 - int'(b) : int'(b);
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    if (LZB && h == 4'd0) begin
      h = 4'hF;
      if (t == 4'd0) t = 4'hF;
    end
    return {neg ? 4'hA : 4'hF, h, t, u};
  endfunction

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               nm, act, exp);
    end
  endtask

  task automatic run(
    input logic [7:0]  b,
    input logic        s,
    input logic [15:0] exp,
    input string       nm
  );
    int nd;
    int nb;
    @(negedge clk);
    check({nm, " idle busy"}, 32'(bus.busy_o), 0);
    bus.start_i = 1'b1;
    bus.bin_i   = b;
    bus.sign_i  = s;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.bin_i   = 8'($urandom);
    bus.sign_i  = 1'($urandom);
    n_exp_done++;
    nd = 0;
    nb = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      nb += int'(bus.busy_o);
      nd += int'(bus.done_o);
    end
    check({nm, " done at N+9"}, 32'(bus.done_o), 1);
    check({nm, " num"}, 32'(bus.num_o), 32'(exp));
    check({nm, " busy cycles"}, nb, 9);
    check({nm, " done pulses"}, nd, 1);
  endtask

  initial begin
    int         nd;
    int         nb;
    int         d0;
    logic [15:0] cap;

    vecs[0]  = '{8'hFF, 1'b0, 16'hF255, 16'hF255};
    vecs[1]  = '{8'h80, 1'b1, 16'hA128, 16'hA128};
    vecs[2]  = '{8'hFF, 1'b1, 16'hA001, 16'hAFF1};
    vecs[3]  = '{8'h00, 1'b0, 16'hF000, 16'hFFF0};
    vecs[4]  = '{8'h0C, 1'b0, 16'hF012, 16'hFF12};
    vecs[5]  = '{8'h00, 1'b1, 16'hF000, 16'hFFF0};
    vecs[6]  = '{8'h7F, 1'b1, 16'hF127, 16'hF127};
    vecs[7]  = '{8'h81, 1'b1, 16'hA127, 16'hA127};
    vecs[8]  = '{8'h64, 1'b0, 16'hF100, 16'hF100};
    vecs[9]  = '{8'h0A, 1'b1, 16'hF010, 16'hFF10};
    vecs[10] = '{8'hF6, 1'b1, 16'hA010, 16'hAF10};
    vecs[11] = '{8'h80, 1'b0, 16'hF128, 16'hF128};
    vecs[12] = '{8'hC8, 1'b0, 16'hF200, 16'hF200};
    vecs[13] = '{8'h09, 1'b0, 16'hF009, 16'hFFF9};

    bus.start_i = 1'b0;
    bus.sign_i  = 1'b0;
    bus.bin_i   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy_o), 0);
    check("reset done", 32'(bus.done_o), 0);
    check("reset num", 32'(bus.num_o), 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run(vecs[i].bin, vecs[i].sign,
          LZB ? vecs[i].e_lzb : vecs[i].e_plain,
          $sformatf("vec%0d", i));
    end

    // reset lands in cycle N+4 of an 8'hFF conversion
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.bin_i   = 8'hFF;
    bus.sign_i  = 1'b0;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst busy", 32'(bus.busy_o), 0);
    check("midrst done", 32'(bus.done_o), 0);
    check("midrst num", 32'(bus.num_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    d0 = n_done;
    repeat (12) @(negedge clk);
    check("midrst no done", n_done, d0);
    run(8'hFF, 1'b0, ref_num(8'hFF, 1'b0), "post rst");

    // starts at N+3 and in DONE must be dropped
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.bin_i   = 8'h2A;
    bus.sign_i  = 1'b0;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    n_exp_done++;
    nd = 0;
    nb = 0;
    cap = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      nb += int'(bus.busy_o);
      nd += int'(bus.done_o);
      if (k == 9) cap = bus.num_o;
      bus.start_i = (k == 3) || (k == 9);
      bus.bin_i   = (k == 3) ? 8'h99 : 8'h11;
      bus.sign_i  = (k == 3);
    end
    check("busy start num", 32'(cap),
          32'(ref_num(8'h2A, 1'b0)));
    check("busy start pulses", nd, 1);
    check("busy start cycles", nb, 9);
    run(8'h37, 1'b0, ref_num(8'h37, 1'b0),
        "start at N+10");

    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 256; v++) begin
        run(8'(v), 1'(s), ref_num(8'(v), 1'(s)),
            $sformatf("sweep s%0d v%0d", s, v));
      end
    end

    repeat (3) @(negedge clk);
    check("total done pulses", n_done, n_exp_done);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end
endmodule
